// File: rtl/sd_cmd_phy_if.sv
// Command/response handshake between the SD controller sequencer and the
// command-line PHY. Signal names keep the PHY-side i_/o_ direction affixes
// so they line up with the PHY datasheet.
interface sd_cmd_phy_if;
  logic         i_fast;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [5:0]   i_cmd_index;
  logic [31:0]  i_cmd_arg;
  logic [1:0]   i_resp_type;
  logic         o_resp_valid;
  logic [5:0]   o_resp_index;
  logic [127:0] o_resp_data;
  logic         o_resp_crc_err;
  logic         o_resp_timeout;

  // controller side
  modport master (
    output i_fast, i_cmd_valid, i_cmd_index, i_cmd_arg, i_resp_type,
    input  o_cmd_ready, o_resp_valid, o_resp_index, o_resp_data,
           o_resp_crc_err, o_resp_timeout
  );

  // PHY side
  modport slave (
    input  i_fast, i_cmd_valid, i_cmd_index, i_cmd_arg, i_resp_type,
    output o_cmd_ready, o_resp_valid, o_resp_index, o_resp_data,
           o_resp_crc_err, o_resp_timeout
  );
endinterface

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: free-running sd_clk divider, 48-bit command
// serialiser with on-the-fly CRC7, response receiver (R1/R2/R3) with NCR
// timeout and CRC7 check, and an 8-clock NCC gap before completion.
module sd_cmd_phy #(
  parameter int INIT_HALF    = 125,
  parameter int FAST_HALF    = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sd_cmd_phy_if.slave cmd,
  output logic        o_sd_clk,
  output logic        o_sd_cmd,
  output logic        o_sd_cmd_oe,
  input  logic        i_sd_cmd
);

  localparam int HW = $clog2((INIT_HALF > FAST_HALF) ? INIT_HALF : FAST_HALF) + 1;
  localparam int CW = $clog2(((RESP_TIMEOUT > 136) ? RESP_TIMEOUT : 136) + 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NCC} state_t;

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic [HW-1:0]  half_q, div_cnt;
  logic           sd_clk_q, tick, rise, fall;
  logic           accept;
  logic [1:0]     type_q;
  logic [39:0]    tx_sr;
  logic [6:0]     crc_q;
  logic [CW-1:0]  bit_cnt;
  logic [127:0]   rx_sr;
  logic           to_q;
  logic           sd_cmd_q, oe_q, tx_bit;
  logic           resp_valid_q, resp_crc_q, resp_to_q;
  logic [5:0]     resp_idx_q, resp_idx_d;
  logic [127:0]   resp_data_q, resp_data_d;
  logic           resp_crc_d;

  // serial CRC7, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // >= so a shorter ratio latched mid-count wraps at once instead of overrunning
  assign tick   = (div_cnt >= half_q - HW'(1));
  assign rise   = tick & ~sd_clk_q;
  assign fall   = tick &  sd_clk_q;
  assign accept = cmd.i_cmd_valid & ready_q & (state_q == S_IDLE);

  // free-running sd_clk half-period divider
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt  <= '0;
      sd_clk_q <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sd_clk_q <= ~sd_clk_q;
    end else begin
      div_cnt  <= div_cnt + HW'(1);
    end
  end

  // state register; ready is registered so it stays low while in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // next-state logic, advanced only on sd_clk strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_TX;
      S_TX:   if (fall && bit_cnt == CW'(48))
                state_d = (type_q == 2'd0) ? S_NCC : S_WAIT;
      S_WAIT: if (rise) begin
                if (!i_sd_cmd)                            state_d = S_RX;
                else if (bit_cnt == CW'(RESP_TIMEOUT - 1)) state_d = S_NCC;
              end
      S_RX:   if (rise && bit_cnt == CW'(1)) state_d = S_NCC;
      S_NCC:  if (rise && bit_cnt == CW'(7)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs: ready, next command bit, and the response fields at completion
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    if (bit_cnt < CW'(40))      tx_bit = tx_sr[39];
    else if (bit_cnt < CW'(47)) tx_bit = crc_q[6];
    else                        tx_bit = 1'b1;
    resp_idx_d  = '0;
    resp_data_d = '0;
    resp_crc_d  = 1'b0;
    if (!to_q) begin
      case (type_q)
        2'd1: begin
          resp_idx_d  = rx_sr[45:40];
          resp_data_d = {96'b0, rx_sr[39:8]};
          resp_crc_d  = (crc_q != rx_sr[7:1]) || !rx_sr[0];
        end
        2'd2: resp_data_d = rx_sr;
        2'd3: begin
          resp_idx_d  = rx_sr[45:40];
          resp_data_d = {96'b0, rx_sr[39:8]};
        end
        default: ;
      endcase
    end
  end

  // datapath: frame shift/CRC, response capture, counters, result registers.
  // The card changes CMD on falling sd_clk, so the pad is half a period stable
  // at every rise strobe and is sampled directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half_q       <= HW'(INIT_HALF);
      type_q       <= '0;
      tx_sr        <= '0;
      crc_q        <= '0;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      to_q         <= 1'b0;
      sd_cmd_q     <= 1'b1;
      oe_q         <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_data_q  <= '0;
      resp_crc_q   <= 1'b0;
      resp_to_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          half_q  <= cmd.i_fast ? HW'(FAST_HALF) : HW'(INIT_HALF);
          type_q  <= cmd.i_resp_type;
          tx_sr   <= {2'b01, cmd.i_cmd_index, cmd.i_cmd_arg};
          crc_q   <= '0;
          bit_cnt <= '0;
          rx_sr   <= '0;
          to_q    <= 1'b0;
        end
        S_TX: if (fall) begin
          if (bit_cnt == CW'(48)) begin
            // last bit has now been held a full period: release the line
            oe_q     <= 1'b1;
            sd_cmd_q <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            oe_q     <= 1'b0;
            sd_cmd_q <= tx_bit;
            bit_cnt  <= bit_cnt + CW'(1);
            if (bit_cnt < CW'(40)) begin
              tx_sr <= {tx_sr[38:0], 1'b0};
              crc_q <= crc7_step(crc_q, tx_sr[39]);
            end else begin
              crc_q <= {crc_q[5:0], 1'b0};
            end
          end
        end
        S_WAIT: if (rise) begin
          if (!i_sd_cmd) begin
            // start bit is 0, so it leaves a zero CRC untouched
            bit_cnt <= (type_q == 2'd2) ? CW'(135) : CW'(47);
            crc_q   <= '0;
          end else if (bit_cnt == CW'(RESP_TIMEOUT - 1)) begin
            bit_cnt <= '0;
            to_q    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_RX: if (rise) begin
          // bit_cnt is the number of bits still to come; > 8 covers bits 46:8
          rx_sr   <= {rx_sr[126:0], i_sd_cmd};
          if (bit_cnt > CW'(8)) crc_q <= crc7_step(crc_q, i_sd_cmd);
          bit_cnt <= bit_cnt - CW'(1);
        end
        S_NCC: if (rise) begin
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(7)) begin
            resp_valid_q <= 1'b1;
            resp_idx_q   <= resp_idx_d;
            resp_data_q  <= resp_data_d;
            resp_crc_q   <= resp_crc_d;
            resp_to_q    <= to_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sd_clk           = sd_clk_q;
  assign o_sd_cmd           = sd_cmd_q;
  assign o_sd_cmd_oe        = oe_q;
  assign cmd.o_cmd_ready    = ready_q;
  assign cmd.o_resp_valid   = resp_valid_q;
  assign cmd.o_resp_index   = resp_idx_q;
  assign cmd.o_resp_data    = resp_data_q;
  assign cmd.o_resp_crc_err = resp_crc_q;
  assign cmd.o_resp_timeout = resp_to_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: vector table of commands, a behavioural SD card on
// the CMD pad, and a response scoreboard fed at command issue.
`timescale 1ns/1ps
module tb_sd_cmd_phy;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_cmd_phy_if bus();
  logic sd_clk, sd_cmd, sd_oe, pad;
  logic card_drv = 1'b1;
  assign pad = sd_oe ? card_drv : sd_cmd;

  sd_cmd_phy #(.INIT_HALF(125), .FAST_HALF(2), .RESP_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .cmd(bus),
    .o_sd_clk(sd_clk), .o_sd_cmd(sd_cmd), .o_sd_cmd_oe(sd_oe), .i_sd_cmd(pad)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) begin
      if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  localparam logic [127:0] CID = 128'h1D41_4453_4344_3330_1012_3456_7801_4A1F;
  localparam logic [31:0]  OCR = 32'hC0FF_8000;

  // card modes: 0 silent, 1 R1 echo, 2 R1 with CRC bit flipped, 3 R2 CID, 4 R3 OCR
  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    logic         fast;
    int           card;
    logic [47:0]  fixed_frame;
    logic         has_fixed;
    logic [5:0]   exp_idx;
    logic [127:0] exp_data;
    logic         exp_crc;
    logic         exp_to;
    int           rises;
    int           per;
  } vec_t;

  typedef struct {
    logic [5:0]   idx;
    logic [127:0] data;
    logic         crc;
    logic         to;
    int           rises;
  } exp_t;

  exp_t sbq[$];
  int   resp_seen = 0;

  // card model state
  int           card_mode = 0;
  logic [135:0] card_resp = '0;
  int           card_len = 0;
  logic [47:0]  cap_frame = '0;
  time          t_r1 = 0, t_r2 = 0, t_oe_fall = 0, t_oe_rise = 0;
  int           rise_cnt = 0, rel_rise = 0;

  always @(posedge sd_clk) rise_cnt <= rise_cnt + 1;
  always @(negedge sd_oe) t_oe_fall = $time;
  always @(posedge sd_oe) begin
    t_oe_rise = $time;
    rel_rise  = rise_cnt;
  end

  // behavioural card: latch the command on rising sd_clk, answer on falling
  initial begin : card
    int nb;
    forever begin
      @(negedge sd_oe);
      nb = 0;
      while (nb < 48) begin
        @(posedge sd_clk);
        if (sd_oe) break;
        cap_frame = {cap_frame[46:0], sd_cmd};
        if (nb == 0) t_r1 = $time;
        if (nb == 1) t_r2 = $time;
        nb++;
      end
      if (nb == 48 && card_mode != 0) begin
        @(negedge sd_clk);
        @(negedge sd_clk);
        for (int k = card_len - 1; k >= 0; k--) begin
          card_drv = card_resp[k];
          @(negedge sd_clk);
        end
        card_drv = 1'b1;
      end
    end
  end

  // scoreboard: every completion pulse must match the oldest issued command
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.o_resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        chk("resp_index",   bus.o_resp_index,   e.idx);
        chk("resp_data",    bus.o_resp_data,    e.data);
        chk("resp_crc_err", bus.o_resp_crc_err, e.crc);
        chk("resp_timeout", bus.o_resp_timeout, e.to);
        chk("ready_w_resp", bus.o_cmd_ready,    1'b1);
        if (e.rises != 0) chk("rises_to_resp", rise_cnt - rel_rise, e.rises);
      end
      resp_seen++;
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_sd_clk"},   sd_clk,             1'b0);
    chk({tag, "_sd_cmd"},   sd_cmd,             1'b1);
    chk({tag, "_oe"},       sd_oe,              1'b1);
    chk({tag, "_ready"},    bus.o_cmd_ready,    1'b0);
    chk({tag, "_valid"},    bus.o_resp_valid,   1'b0);
    chk({tag, "_crc_err"},  bus.o_resp_crc_err, 1'b0);
    chk({tag, "_timeout"},  bus.o_resp_timeout, 1'b0);
    chk({tag, "_index"},    bus.o_resp_index,   6'd0);
    chk({tag, "_data"},     bus.o_resp_data,    128'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.o_cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", bus.o_cmd_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [39:0] body;
    logic [47:0] r48;
    int          n, seen0;
    body = {2'b01, v.idx, v.arg};
    card_mode = v.card;
    case (v.card)
      1, 2: begin
        r48 = {2'b00, v.idx, v.arg, crc7({2'b00, v.idx, v.arg}), 1'b1};
        if (v.card == 2) r48 = r48 ^ 48'h2;
        card_resp = {88'b0, r48};
        card_len  = 48;
      end
      3: begin
        card_resp = {2'b00, 6'h3F, CID};
        card_len  = 136;
      end
      4: begin
        card_resp = {88'b0, 2'b00, 6'h3F, OCR, 7'h7F, 1'b1};
        card_len  = 48;
      end
      default: card_len = 0;
    endcase
    wait_ready();
    bus.i_fast      = v.fast;
    bus.i_cmd_index = v.idx;
    bus.i_cmd_arg   = v.arg;
    bus.i_resp_type = v.rtype;
    bus.i_cmd_valid = 1'b1;
    e = '{v.exp_idx, v.exp_data, v.exp_crc, v.exp_to, v.rises};
    sbq.push_back(e);
    seen0 = resp_seen;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    chk("ready_drop", bus.o_cmd_ready, 1'b0);
    // divide ratio must stay latched; a stray request must be ignored
    bus.i_fast = ~v.fast;
    @(negedge clk);
    @(negedge clk);
    bus.i_cmd_index = 6'h3F;
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    n = 0;
    while (resp_seen == seen0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrived", resp_seen - seen0, 1);
    chk("cmd_frame", cap_frame, {body, crc7(body), 1'b1});
    if (v.has_fixed) chk("cmd_frame_const", cap_frame, v.fixed_frame);
    chk("sd_clk_period", t_r2 - t_r1, v.per);
    chk("oe_low_time", t_oe_rise - t_oe_fall, 48 * v.per);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    bus.i_fast      = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_index = '0;
    bus.i_cmd_arg   = '0;
    bus.i_resp_type = '0;

    //           idx    arg            ty fast card fixed_frame          fx exp_idx exp_data              crc to rises per
    vecs[0] = '{6'd0,  32'h0,          2'd0, 1'b0, 0, 48'h40_0000_0000_95, 1'b1, 6'd0,  128'h0,               1'b0, 1'b0, 8,  2500};
    vecs[1] = '{6'd8,  32'h0000_01AA,  2'd1, 1'b1, 1, 48'h48_0000_01AA_87, 1'b1, 6'd8,  128'h1AA,             1'b0, 1'b0, 0,  40};
    vecs[2] = '{6'd55, 32'hA5A5_0F0F,  2'd1, 1'b1, 1, 48'h0,               1'b0, 6'd55, 128'hA5A5_0F0F,       1'b0, 1'b0, 0,  40};
    vecs[3] = '{6'd17, 32'h1234_5678,  2'd1, 1'b1, 2, 48'h0,               1'b0, 6'd17, 128'h1234_5678,       1'b1, 1'b0, 0,  40};
    vecs[4] = '{6'd2,  32'h0,          2'd2, 1'b1, 3, 48'h0,               1'b0, 6'd0,  CID,                  1'b0, 1'b0, 0,  40};
    vecs[5] = '{6'd13, 32'h0001_0000,  2'd1, 1'b1, 0, 48'h0,               1'b0, 6'd0,  128'h0,               1'b0, 1'b1, 72, 40};
    vecs[6] = '{6'd41, 32'h40FF_8000,  2'd3, 1'b1, 4, 48'h0,               1'b0, 6'h3F, {96'b0, OCR},         1'b0, 1'b0, 0,  40};
    vecs[7] = '{6'd0,  32'h0,          2'd0, 1'b1, 0, 48'h40_0000_0000_95, 1'b1, 6'd0,  128'h0,               1'b0, 1'b0, 8,  40};

    // reset state
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.o_cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset in the middle of a slow command frame
    card_mode = 0;
    wait_ready();
    bus.i_fast      = 1'b0;
    bus.i_cmd_index = 6'd0;
    bus.i_cmd_arg   = 32'h0;
    bus.i_resp_type = 2'd0;
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    n = 0;
    while (sd_oe !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_started", sd_oe, 1'b0);
    repeat (1100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midtx");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midtx", bus.o_cmd_ready, 1'b1);

    run_vec(vecs[7]);

    repeat (20) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_phy.md
# sd_cmd_phy

SD-card command-line engine inside `super6502_fpga`: it generates `o_sd_clk` and drives `o_sd_cmd`/`o_sd_cmd_oe` out to the external SD card (the `mdl_sdio` card model in simulation). Upstream, the SD controller's register/sequencing logic hands it one command at a time (index + argument + response type). The block serialises the 48-bit frame with CRC7, receives the R1/R2/R3 response with a timeout, checks CRC7, and returns the fields. Data-line (DAT0) transfers live in a separate block.

## Interface
- `INIT_HALF`, 125: system clocks per sd_clk half-period in slow mode (100 MHz → 400 kHz).
- `FAST_HALF`, 2: system clocks per sd_clk half-period in fast mode (100 MHz → 25 MHz); must be ≥ 2.
- `RESP_TIMEOUT`, 64: sd_clk rising edges allowed between command end bit and response start bit (NCR).
- `i_clk`  in  1  system clock (i_sysclk domain). One clock only.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_fast`  in  1  selects FAST_HALF; sampled only in IDLE.
- `i_cmd_valid`  in  1  command request; accepted when `o_cmd_ready` is high in the same cycle.
- `o_cmd_ready`  out  1  high only in IDLE.
- `i_cmd_index`  in  6  command index.
- `i_cmd_arg`  in  32  command argument.
- `i_resp_type`  in  2  0 = none, 1 = R1 (48-bit, CRC checked), 2 = R2 (136-bit, no CRC check), 3 = R3 (48-bit, no CRC check).
- `o_resp_valid`  out  1  one-cycle completion pulse for every accepted command.
- `o_resp_index`  out  6  response bits 45:40 (48-bit responses); 0 for R2/none.
- `o_resp_data`  out  128  48-bit responses: [31:0] = bits 39:8, upper bits 0. R2: raw bits 127:0.
- `o_resp_crc_err`  out  1  valid with `o_resp_valid`; CRC7 mismatch or end bit ≠ 1 (R1 only).
- `o_resp_timeout`  out  1  valid with `o_resp_valid`; no start bit within RESP_TIMEOUT.
- `o_sd_clk`  out  1  SD clock.
- `o_sd_cmd`  out  1  CMD output value.
- `o_sd_cmd_oe`  out  1  tristate control for the CMD IOBUF: 1 = release the line (pulled up), 0 = drive `o_sd_cmd`.
- `i_sd_cmd`  in  1  CMD line as seen at the pad.

## Operation
- Reset values: `o_sd_clk` = 0, `o_sd_cmd` = 1, `o_sd_cmd_oe` = 1, `o_cmd_ready` = 0 (it goes to 1 on the first cycle after release), `o_resp_valid`/`o_resp_crc_err`/`o_resp_timeout` = 0, and `o_resp_index`/`o_resp_data` = 0.
- The clock divider free-runs whenever the block is out of reset. A half-period counter toggles `o_sd_clk`, producing two internal strobes:
  - rise: the cycle in which `o_sd_clk` goes 0→1.
  - fall: the cycle in which `o_sd_clk` goes 1→0.
- The divide ratio is latched on command accept.
- Frame: `01 idx[5:0] arg[31:0] crc7[6:0] 1`, sent MSB first.
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - The CRC is computed serially during transmission.
- States:
  - IDLE: on accept, latch index/arg/type, then go to TX.
  - TX: each bit is driven on a fall strobe, with `o_sd_cmd_oe` = 0. After the 48th bit has been held for a full sd_clk period, release (`oe` = 1). Type 0 → NCC; otherwise → WAIT.
  - WAIT: on each rise, sample `i_sd_cmd`.
    - A 0 sample means start bit → RX.
    - After RESP_TIMEOUT rises with no start bit → NCC, flagged as timeout.
  - RX: shift on each rise; 47 remaining bits for types 1/3, 135 for type 2. For type 1, CRC7 runs over response bits 47:8. Then → NCC.
  - NCC: 8 rises with the line released. Then `o_resp_valid` pulses for one cycle with final flags and fields, and the state returns to IDLE.
- Response handling:
  - A timeout leaves `o_resp_index`/`o_resp_data` at 0.
  - Output fields hold their value until the next `o_resp_valid`.
- Commands arriving while not ready are ignored. There is no abort: an asynchronous reset mid-command returns all outputs to their reset values immediately.

## Timing
- Command bits change only on fall strobes; response bits are sampled only on rise strobes.
- Accept → first start-bit drive: at most one sd_clk period.
- A type-0 command occupies 48 + 8 sd_clk periods (±1) from first bit to `o_resp_valid`.
- `o_cmd_ready` drops in the cycle after accept and rises in the same cycle as the `o_resp_valid` pulse.
- `i_fast` toggling mid-command has no effect until the next accept.

## Test plan
- CMD0, arg 0, type 0, slow mode:
  - CMD pin shows 0x40 00 00 00 00 95.
  - `oe` = 0 for exactly 48 sd_clk periods.
  - sd_clk period is 2500 ns.
  - `o_resp_valid` with `o_resp_crc_err` = 0 and `o_resp_timeout` = 0.
- CMD8, arg 0x1AA, type 1, against the card model:
  - Last frame byte is 0x87.
  - Response gives `o_resp_index` = 8, `o_resp_data[31:0]` = 0x000001AA, `o_resp_crc_err` = 0.
- Type 1 with the card removed (line pulled up): `o_resp_valid` with `o_resp_timeout` = 1 after 64 sd_clk rises + NCC; data = 0.
- CMD2 (type 2), fast mode:
  - sd_clk period is 40 ns.
  - 136 bits received; `o_resp_data` matches the model's CID bits 127:0.
- R1 with one bit of the response CRC flipped by the bench drive: `o_resp_crc_err` = 1, timeout = 0.
- Assert `i_rst_n` low during TX:
  - All outputs return to reset values immediately (`oe` = 1).
  - After release, a new CMD0 completes normally.
